// File: rtl/instr_expand_queue.sv
// Instruction-queue buffer that expands each entry into up to eight strided copies
// and issues up to ISSUE_WIDTH of them per cycle to the execution front end.
module instr_expand_queue #(
  parameter int DEPTH       = 16,
  parameter int ISSUE_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic [15:0]                 push_instr,
  input  logic [3:0]                  push_copy_cnt,
  input  logic [17:0]                 push_cache_addr,
  input  logic [17:0]                 push_main_mem_addr,
  input  logic [17:0]                 push_d_cache_addr,
  input  logic [17:0]                 push_d_main_mem_addr,
  output logic [ISSUE_WIDTH-1:0]      out_valid,
  output logic [16*ISSUE_WIDTH-1:0]   out_instr,
  output logic [18*ISSUE_WIDTH-1:0]   out_cache_addr,
  output logic [18*ISSUE_WIDTH-1:0]   out_main_mem_addr,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0] r_instr [DEPTH];
  logic [3:0]  r_cnt   [DEPTH];
  logic [17:0] r_ca    [DEPTH];
  logic [17:0] r_dca   [DEPTH];
  logic [17:0] r_ma    [DEPTH];
  logic [17:0] r_dma   [DEPTH];

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [2:0]  r_idx;

  logic [AW-1:0] w_head;
  logic [3:0]    w_cnt_norm;
  logic [3:0]    w_n;
  logic          w_full;
  logic          w_push;
  logic          w_issue;
  logic          w_retire;

  assign w_head     = r_rd[AW-1:0];
  assign w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign push_ready = !w_full;
  assign count      = r_wr - r_rd;
  assign empty      = (r_wr == r_rd);
  assign w_push     = push_valid && push_ready && !flush;

  // Copy counts are stored already clamped to 1..8.
  always_comb begin
    w_cnt_norm = push_copy_cnt;
    if (push_copy_cnt == 4'd0)
      w_cnt_norm = 4'd1;
    else if (push_copy_cnt > 4'd8)
      w_cnt_norm = 4'd8;
  end

  // Lanes only ever cover copies of the head entry.
  always_comb begin
    out_valid         = '0;
    out_instr         = '0;
    out_cache_addr    = '0;
    out_main_mem_addr = '0;
    w_n               = 4'd0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (!empty && (({2'b00, r_idx} + 5'(i)) < {1'b0, r_cnt[w_head]})) begin
        out_valid[i]               = 1'b1;
        out_instr[16*i +: 16]      = r_instr[w_head];
        out_cache_addr[18*i +: 18] = r_ca[w_head] +
                                     18'(({15'd0, r_idx} + 18'(i)) * r_dca[w_head]);
        out_main_mem_addr[18*i +: 18] = r_ma[w_head] +
                                     18'(({15'd0, r_idx} + 18'(i)) * r_dma[w_head]);
        w_n = w_n + 4'd1;
      end
    end
  end

  assign w_issue  = out_ready && out_valid[0];
  assign w_retire = w_issue && (({1'b0, r_idx} + w_n) == r_cnt[w_head]);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_idx <= 3'd0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_retire) begin
        r_rd  <= r_rd + 1'b1;
        r_idx <= 3'd0;
      end else if (w_issue) begin
        r_idx <= 3'({1'b0, r_idx} + w_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr[AW-1:0]] <= push_instr;
      r_cnt[r_wr[AW-1:0]]   <= w_cnt_norm;
      r_ca[r_wr[AW-1:0]]    <= push_cache_addr;
      r_dca[r_wr[AW-1:0]]   <= push_d_cache_addr;
      r_ma[r_wr[AW-1:0]]    <= push_main_mem_addr;
      r_dma[r_wr[AW-1:0]]   <= push_d_main_mem_addr;
    end
  end

endmodule

// File: tb/tb_instr_expand_queue.sv
// Bench for instr_expand_queue: directed scenarios plus random traffic, all
// checked against a queue-of-entries reference model.
module tb_instr_expand_queue;
  localparam int DEPTH = 16;
  localparam int IW    = 3;

  logic              clk = 1'b0;
  logic              reset, flush, push_valid, push_ready, out_ready, empty;
  logic [15:0]       push_instr;
  logic [3:0]        push_copy_cnt;
  logic [17:0]       push_cache_addr, push_main_mem_addr;
  logic [17:0]       push_d_cache_addr, push_d_main_mem_addr;
  logic [IW-1:0]     out_valid;
  logic [16*IW-1:0]  out_instr;
  logic [18*IW-1:0]  out_cache_addr, out_main_mem_addr;
  logic [4:0]        count;

  instr_expand_queue #(.DEPTH(DEPTH), .ISSUE_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_instr(push_instr), .push_copy_cnt(push_copy_cnt),
    .push_cache_addr(push_cache_addr), .push_main_mem_addr(push_main_mem_addr),
    .push_d_cache_addr(push_d_cache_addr), .push_d_main_mem_addr(push_d_main_mem_addr),
    .out_valid(out_valid), .out_instr(out_instr),
    .out_cache_addr(out_cache_addr), .out_main_mem_addr(out_main_mem_addr),
    .out_ready(out_ready), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          cnt;
    logic [17:0] ca, dca, ma, dma;
  } ent_t;

  ent_t q[$];
  int   m_idx = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("push_ready", push_ready, q.size() < DEPTH);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    for (int i = 0; i < IW; i++) begin
      logic        ev;
      logic [15:0] ei;
      logic [17:0] ec, em;
      ev = 0; ei = 0; ec = 0; em = 0;
      if (q.size() > 0 && m_idx + i < q[0].cnt) begin
        ev = 1;
        ei = q[0].instr;
        ec = 18'(q[0].ca + (m_idx + i) * q[0].dca);
        em = 18'(q[0].ma + (m_idx + i) * q[0].dma);
      end
      check($sformatf("valid[%0d]", i), out_valid[i], ev);
      check($sformatf("instr[%0d]", i), out_instr[16*i +: 16], ei);
      check($sformatf("cache[%0d]", i), out_cache_addr[18*i +: 18], ec);
      check($sformatf("main[%0d]", i), out_main_mem_addr[18*i +: 18], em);
    end
  endtask

  task automatic model_step();
    bit do_push;
    do_push = push_valid && (q.size() < DEPTH) && !flush;
    if (reset || flush) begin
      q.delete();
      m_idx = 0;
      return;
    end
    if (out_ready && q.size() > 0) begin
      int left, n;
      left = q[0].cnt - m_idx;
      n = (left < IW) ? left : IW;
      if (n == left) begin
        void'(q.pop_front());
        m_idx = 0;
      end else begin
        m_idx += n;
      end
    end
    if (do_push) begin
      ent_t e;
      e.instr = push_instr;
      e.cnt   = (push_copy_cnt == 0) ? 1 : ((push_copy_cnt > 8) ? 8 : int'(push_copy_cnt));
      e.ca = push_cache_addr;   e.dca = push_d_cache_addr;
      e.ma = push_main_mem_addr; e.dma = push_d_main_mem_addr;
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_push(input bit v, input logic [3:0] c, input logic [17:0] ca,
                          input logic [17:0] dca, input logic [17:0] ma,
                          input logic [17:0] dma, input logic [15:0] ins);
    push_valid = v; push_copy_cnt = c; push_instr = ins;
    push_cache_addr = ca; push_d_cache_addr = dca;
    push_main_mem_addr = ma; push_d_main_mem_addr = dma;
  endtask

  initial begin
    reset = 1; flush = 0; out_ready = 0;
    set_push(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    repeat (5) tick();

    // Eight copies, wrapping main address.
    out_ready = 1;
    set_push(1, 8, 18'd100, 18'd4, 18'h3FFFE, 18'd1, 16'hA5A5);
    tick();
    push_valid = 0;
    repeat (5) tick();

    // Fill to full, then steady pop+push across pointer wrap.
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      set_push(1, 1, 18'(i), 18'd0, 18'(1000 + i), 18'd0, 16'(i));
      tick();
    end
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      set_push(1, 1, 18'(200 + i), 18'd0, 18'(3000 + i), 18'd0, 16'(16'h100 + i));
      tick();
    end
    push_valid = 0;
    repeat (DEPTH + 2) tick();

    // Negative stride.
    set_push(1, 4, 18'd2, 18'h3FFFF, 18'd50, 18'h3FFFE, 16'h1234);
    tick();
    push_valid = 0;
    repeat (3) tick();

    // Hold with two queued entries, then clamped counts.
    out_ready = 0;
    set_push(1, 5, 18'd10, 18'd3, 18'd20, 18'd7, 16'h0005);
    tick();
    set_push(1, 0, 18'd40, 18'd1, 18'd60, 18'd1, 16'h0000);
    tick();
    push_valid = 0;
    repeat (3) tick();
    set_push(1, 15, 18'd7, 18'd9, 18'd8, 18'd2, 16'h000F);
    out_ready = 1;
    tick();
    push_valid = 0;
    repeat (8) tick();

    // Flush with head half issued and a simultaneous push.
    out_ready = 0;
    set_push(1, 8, 18'd300, 18'd2, 18'd400, 18'd3, 16'hBEEF);
    tick();
    push_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    flush = 1;
    set_push(1, 2, 18'd1, 18'd1, 18'd1, 18'd1, 16'hDEAD);
    tick();
    flush = 0;
    push_valid = 0;
    repeat (2) tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      set_push($urandom_range(0, 2) != 0, 4'($urandom), 18'($urandom), 18'($urandom),
               18'($urandom), 18'($urandom), 16'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 127) == 0);
      reset = (c == 1500);
      tick();
    end
    flush = 0; reset = 0; push_valid = 0; out_ready = 1;
    repeat (DEPTH * 3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
